// File: rtl/text_write_ctrl.sv
// Character-buffer write sequencer: buffers ASCII codes in a small FIFO and commits
// them, along with full-screen clears, only while the display is in vertical blanking.
`timescale 1ns/1ps
module text_write_ctrl #(
    parameter int COLS       = 16,
    parameter int ROWS       = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vblnk,
    input  logic [6:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clear_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [6:0]    wr_data,
    output logic          busy
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_BS    = 7'h08;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_WRITE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_addr_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            clear_pending_q;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [6:0]      wr_data_q;

    logic [6:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;
    logic [PW:0]     count_d;

    logic            fifo_full;
    logic            fifo_nonempty;
    logic            push;
    logic            pop;
    logic [6:0]      head;
    logic [CW-1:0]   col_inc;
    logic [CW-1:0]   col_dec;
    logic [RW-1:0]   row_inc;
    logic            col_last;

    assign fifo_full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign push          = in_valid & ~fifo_full;
    assign pop           = (state_q == S_WRITE) & vblnk & fifo_nonempty;
    assign head          = fifo_mem[rd_ptr_q];

    assign col_inc  = col_q + CW'(1);
    assign col_dec  = col_q - CW'(1);
    assign row_inc  = row_q + RW'(1);
    assign col_last = (col_q == CW'(COLS - 1));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            clr_addr_q      <= '0;
            row_q           <= '0;
            col_q           <= '0;
            clear_pending_q <= 1'b1;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (vblnk && clear_pending_q) begin
                        state_q         <= S_CLEAR;
                        clr_addr_q      <= '0;
                        row_q           <= '0;
                        col_q           <= '0;
                        clear_pending_q <= 1'b0;
                    end else if (vblnk && fifo_nonempty) begin
                        state_q <= S_WRITE;
                    end
                end
                S_CLEAR: begin
                    if (vblnk) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= clr_addr_q;
                        wr_data_q  <= CH_SPACE;
                        clr_addr_q <= clr_addr_q + 1'b1;
                        if (clr_addr_q == AW'(COLS * ROWS - 1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    if (pop) begin
                        if (head == CH_CR) begin
                            col_q <= '0;
                            row_q <= row_inc;
                        end else if (head == CH_BS) begin
                            if (col_q != '0) begin
                                col_q     <= col_dec;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= {row_q, col_dec};
                                wr_data_q <= CH_SPACE;
                            end
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {row_q, col_q};
                            wr_data_q <= head;
                            col_q     <= col_inc;
                            if (col_last) begin
                                row_q <= row_inc;
                            end
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // A request arriving in the same cycle a clear starts is kept for the next one.
            if (clear_req && state_q != S_CLEAR) begin
                clear_pending_q <= 1'b1;
            end
        end
    end

    assign in_ready = ~fifo_full;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = clear_pending_q | (state_q == S_CLEAR) | fifo_nonempty;

endmodule
